// File: rtl/hdpldadapt_cmn_occ_pulse_ctrl_if.sv
// Bundle of the OCC pulse controller's control inputs and gate/status outputs.
//   scan_enable, occ_enable, atpg_mode, burst_cnt : driven by the test/control side
//   occ_user_clken, occ_busy, occ_done, occ_abort : driven by the controller
// master = driver of the control inputs, slave = the controller itself.
interface hdpldadapt_cmn_occ_pulse_ctrl_if #(
    parameter int CNT_W = 2
);
    logic             scan_enable;
    logic             occ_enable;
    logic             atpg_mode;
    logic [CNT_W-1:0] burst_cnt;
    logic             occ_user_clken;
    logic             occ_busy;
    logic             occ_done;
    logic             occ_abort;

    modport master (
        output scan_enable, occ_enable, atpg_mode, burst_cnt,
        input  occ_user_clken, occ_busy, occ_done, occ_abort
    );

    modport slave (
        input  scan_enable, occ_enable, atpg_mode, burst_cnt,
        output occ_user_clken, occ_busy, occ_done, occ_abort
    );
endinterface

// File: rtl/hdpldadapt_cmn_occ_pulse_ctrl.sv
// User-clock OCC pulse controller. Watches scan_enable (synchronized into clk),
// and on a shift->capture transition waits SETTLE_CYC cycles, then opens the
// user-clock gate for exactly burst_cnt+1 cycles. Functional mode holds the gate open.
// Ports:
//   clk    : user clock
//   rst_n  : asynchronous active-low reset
//   occ    : slave side of the control/status interface
//            in : scan_enable (async), occ_enable, atpg_mode, burst_cnt
//            out: occ_user_clken, occ_busy, occ_done, occ_abort (all registered)
module hdpldadapt_cmn_occ_pulse_ctrl #(
    parameter int SYNC_STAGES = 2,
    parameter int SETTLE_CYC  = 4,
    parameter int CNT_W       = 2
) (
    input  logic                            clk,
    input  logic                            rst_n,
    hdpldadapt_cmn_occ_pulse_ctrl_if.slave  occ
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_SETTLE,
        S_PULSE,
        S_DONE
    } state_t;

    localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYC - 1);

    logic [SYNC_STAGES-1:0] se_sync;
    logic                   se_s;

    state_t           state_q, state_d;
    logic [3:0]       settle_q, settle_d;
    logic [CNT_W-1:0] pulse_q, pulse_d;
    logic             clken_q, clken_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             abort_q, abort_d;

    // scan_enable crosses from the test-clock domain; only the last stage is used.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) se_sync <= '0;
        else        se_sync <= {se_sync[SYNC_STAGES-2:0], occ.scan_enable};
    end

    assign se_s = se_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            settle_q <= '0;
            pulse_q  <= '0;
            clken_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            abort_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            pulse_q  <= pulse_d;
            clken_q  <= clken_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            abort_q  <= abort_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        pulse_d  = pulse_q;
        abort_d  = 1'b0;
        clken_d  = 1'b0;

        if (!occ.atpg_mode) begin
            // Functional passthrough: gate open, FSM parked.
            state_d = S_IDLE;
            clken_d = 1'b1;
        end else if (!occ.occ_enable) begin
            // Test clock owns capture; user clock blocked.
            state_d = S_IDLE;
            clken_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // A fall only counts after shift has been observed.
                    if (se_s) state_d = S_ARMED;
                end
                S_ARMED: begin
                    if (!se_s) begin
                        state_d  = S_SETTLE;
                        settle_d = SETTLE_INIT;
                    end
                end
                S_SETTLE: begin
                    // Abort has priority over terminal count.
                    if (se_s) begin
                        state_d = S_ARMED;
                        abort_d = 1'b1;
                    end else if (settle_q == 4'd0) begin
                        state_d = S_PULSE;
                        pulse_d = occ.burst_cnt;
                    end else begin
                        settle_d = settle_q - 4'd1;
                    end
                end
                S_PULSE: begin
                    if (se_s) begin
                        state_d = S_ARMED;
                        abort_d = 1'b1;
                    end else if (pulse_q == '0) begin
                        state_d = S_DONE;
                    end else begin
                        pulse_d = pulse_q - CNT_W'(1);
                    end
                end
                S_DONE: begin
                    if (se_s) state_d = S_ARMED;
                end
                default: state_d = S_IDLE;
            endcase
            // Registered enable tracks the state being entered.
            clken_d = (state_d == S_PULSE);
        end
    end

    assign busy_d = (state_d == S_SETTLE) || (state_d == S_PULSE);
    assign done_d = (state_d == S_DONE);

    assign occ.occ_user_clken = clken_q;
    assign occ.occ_busy       = busy_q;
    assign occ.occ_done       = done_q;
    assign occ.occ_abort      = abort_q;

endmodule

// File: tb/tb_hdpldadapt_cmn_occ_pulse_ctrl.sv
module tb_hdpldadapt_cmn_occ_pulse_ctrl;

    localparam int SYNC   = 2;
    localparam int SETTLE = 4;
    localparam int CNT_W  = 2;
    // Edges from scan_enable fall (driven just after an edge) to first gated cycle.
    localparam int LAT    = SYNC + 1 + SETTLE;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    hdpldadapt_cmn_occ_pulse_ctrl_if #(.CNT_W(CNT_W)) ifc ();

    hdpldadapt_cmn_occ_pulse_ctrl #(
        .SYNC_STAGES (SYNC),
        .SETTLE_CYC  (SETTLE),
        .CNT_W       (CNT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .occ   (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {clken, busy, done, abort}
    function automatic logic [3:0] obs();
        return {ifc.occ_user_clken, ifc.occ_busy, ifc.occ_done, ifc.occ_abort};
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Put the controller in the shift-observed state with scan_enable high.
    task automatic arm();
        ifc.atpg_mode   = 1'b1;
        ifc.occ_enable  = 1'b1;
        ifc.scan_enable = 1'b1;
        tick(SYNC + 2);
    endtask

    // Drop scan_enable and record when the gate opens and how long it stays open.
    task automatic measure(input int bc, input bit chg, output int rise, output int highs,
                           output bit busy_seen);
        ifc.burst_cnt   = CNT_W'(bc);
        ifc.scan_enable = 1'b0;
        rise      = -1;
        highs     = 0;
        busy_seen = 1'b0;
        for (int e = 1; e <= 60; e++) begin
            tick(1);
            if (e == SYNC + 1) busy_seen = ifc.occ_busy;
            if (ifc.occ_user_clken) begin
                if (rise < 0) begin
                    rise = e;
                    if (chg) ifc.burst_cnt = ifc.burst_cnt + CNT_W'(1);
                end
                highs++;
            end else if (rise >= 0) begin
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n           = 1'b0;
        ifc.atpg_mode   = 1'b1;
        ifc.occ_enable  = 1'b1;
        ifc.scan_enable = 1'b0;
        ifc.burst_cnt   = '0;
        tick(3);
        checks++;
        if (obs() !== 4'b1000) begin
            errors++;
            $display("FAIL reset_state: got %b want 1000", obs());
        end
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic test_functional();
        ifc.atpg_mode = 1'b0;
        for (int i = 0; i < 30; i++) begin
            ifc.scan_enable = 1'($urandom);
            ifc.occ_enable  = 1'($urandom);
            ifc.burst_cnt   = CNT_W'($urandom);
            tick(1);
            checks++;
            if (obs() !== 4'b1000) begin
                errors++;
                $display("FAIL functional cyc%0d: got %b want 1000", i, obs());
            end
        end
    endtask

    task automatic test_basic_burst();
        int rise, highs;
        bit busy_seen;
        arm();
        checks++;
        if (obs() !== 4'b0000) begin
            errors++;
            $display("FAIL armed_state: got %b want 0000", obs());
        end
        measure(1, 1'b0, rise, highs, busy_seen);
        checks++;
        if (rise !== LAT) begin
            errors++;
            $display("FAIL basic_rise: got %0d want %0d", rise, LAT);
        end
        checks++;
        if (highs !== 2) begin
            errors++;
            $display("FAIL basic_pulses: got %0d want 2", highs);
        end
        checks++;
        if (busy_seen !== 1'b1) begin
            errors++;
            $display("FAIL basic_busy_settle: got %b want 1", busy_seen);
        end
        checks++;
        if (obs() !== 4'b0010) begin
            errors++;
            $display("FAIL basic_done: got %b want 0010", obs());
        end
        // done clears once the re-rise has passed the synchronizer and FSM edge
        ifc.scan_enable = 1'b1;
        tick(SYNC);
        checks++;
        if (ifc.occ_done !== 1'b1) begin
            errors++;
            $display("FAIL done_hold: got %b want 1", ifc.occ_done);
        end
        tick(1);
        checks++;
        if (obs() !== 4'b0000) begin
            errors++;
            $display("FAIL done_clear: got %b want 0000", obs());
        end
    endtask

    task automatic test_random_bursts();
        int rise, highs, bc;
        bit busy_seen, chg;
        // include the boundary counts first, then random ones
        for (int i = 0; i < 8; i++) begin
            bc  = (i == 0) ? 0 : (i == 1) ? 3 : int'($urandom_range(0, 3));
            chg = (i >= 2) ? 1'($urandom) : 1'b0;
            if (i == 2) chg = 1'b1;
            arm();
            repeat ($urandom_range(0, 3)) tick(1);
            measure(bc, chg, rise, highs, busy_seen);
            checks++;
            if (rise !== LAT || highs !== bc + 1) begin
                errors++;
                $display("FAIL burst%0d bc=%0d chg=%0d: got rise %0d pulses %0d want rise %0d pulses %0d",
                         i, bc, chg, rise, highs, LAT, bc + 1);
            end
            checks++;
            if (ifc.occ_done !== 1'b1) begin
                errors++;
                $display("FAIL burst%0d_done: got %b want 1", i, ifc.occ_done);
            end
        end
    endtask

    task automatic test_abort_settle();
        int abort_at, abort_n, clk_n, rise, highs;
        bit busy_seen;
        arm();
        ifc.scan_enable = 1'b0;
        tick(SYNC + 1);            // now in settle
        ifc.scan_enable = 1'b1;
        abort_at = -1; abort_n = 0; clk_n = 0;
        for (int j = 1; j <= 6; j++) begin
            tick(1);
            if (ifc.occ_abort) begin abort_n++; abort_at = j; end
            if (ifc.occ_user_clken) clk_n++;
        end
        checks++;
        if (abort_n !== 1 || abort_at !== SYNC + 1 || clk_n !== 0) begin
            errors++;
            $display("FAIL abort_settle: got aborts %0d at %0d gated %0d want 1 at %0d gated 0",
                     abort_n, abort_at, clk_n, SYNC + 1);
        end
        checks++;
        if (obs() !== 4'b0000) begin
            errors++;
            $display("FAIL abort_settle_armed: got %b want 0000", obs());
        end
        measure(2, 1'b0, rise, highs, busy_seen);
        checks++;
        if (rise !== LAT || highs !== 3) begin
            errors++;
            $display("FAIL abort_settle_reburst: got rise %0d pulses %0d want %0d 3", rise, highs, LAT);
        end
    endtask

    task automatic test_abort_pulse();
        int raise_e, exp_abort, exp_highs, abort_at, abort_n, highs, rise;
        bit busy_seen;
        arm();
        ifc.burst_cnt   = CNT_W'(3);
        ifc.scan_enable = 1'b0;
        raise_e   = LAT - 1;
        exp_abort = raise_e + SYNC + 1;
        exp_highs = exp_abort - LAT;
        tick(raise_e);
        ifc.scan_enable = 1'b1;
        abort_at = -1; abort_n = 0; highs = 0;
        for (int e = raise_e + 1; e <= raise_e + 8; e++) begin
            tick(1);
            if (ifc.occ_abort) begin abort_n++; abort_at = e; end
            if (ifc.occ_user_clken) highs++;
        end
        checks++;
        if (abort_n !== 1 || abort_at !== exp_abort || highs !== exp_highs) begin
            errors++;
            $display("FAIL abort_pulse: got aborts %0d at %0d pulses %0d want 1 at %0d pulses %0d",
                     abort_n, abort_at, highs, exp_abort, exp_highs);
        end
        checks++;
        if (obs() !== 4'b0000) begin
            errors++;
            $display("FAIL abort_pulse_armed: got %b want 0000", obs());
        end
        measure(3, 1'b0, rise, highs, busy_seen);
        checks++;
        if (rise !== LAT || highs !== 4) begin
            errors++;
            $display("FAIL abort_pulse_reburst: got rise %0d pulses %0d want %0d 4", rise, highs, LAT);
        end
    endtask

    task automatic test_mode();
        int bad, waited;
        ifc.atpg_mode  = 1'b1;
        ifc.occ_enable = 1'b0;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            ifc.scan_enable = 1'($urandom);
            tick(1);
            if (obs() !== 4'b0000) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL occ_off_blocked: got %0d bad cycles want 0", bad);
        end
        arm();
        ifc.burst_cnt   = CNT_W'(3);
        ifc.scan_enable = 1'b0;
        waited = 0;
        while (!ifc.occ_user_clken && waited < 40) begin tick(1); waited++; end
        checks++;
        if (waited >= 40) begin
            errors++;
            $display("FAIL mode_burst_start: got timeout want clken high");
        end
        ifc.occ_enable = 1'b0;
        tick(1);
        checks++;
        if (obs() !== 4'b0000) begin
            errors++;
            $display("FAIL occ_drop_midpulse: got %b want 0000", obs());
        end
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            if (ifc.occ_abort || ifc.occ_user_clken) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL occ_drop_quiet: got %0d bad cycles want 0", bad);
        end
        ifc.atpg_mode = 1'b0;
        tick(1);
        checks++;
        if (obs() !== 4'b1000) begin
            errors++;
            $display("FAIL atpg_drop: got %b want 1000", obs());
        end
    endtask

    task automatic test_reset_mid();
        int waited, bad, rise, highs;
        bit busy_seen;
        arm();
        ifc.burst_cnt   = CNT_W'(3);
        ifc.scan_enable = 1'b0;
        waited = 0;
        while (!ifc.occ_user_clken && waited < 40) begin tick(1); waited++; end
        tick(1);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (obs() !== 4'b1000 || waited >= 40) begin
            errors++;
            $display("FAIL reset_midpulse: got %b waited %0d want 1000 within 40", obs(), waited);
        end
        tick(2);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (ifc.occ_user_clken || ifc.occ_busy) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL reset_no_burst: got %0d active cycles want 0", bad);
        end
        arm();
        measure(1, 1'b0, rise, highs, busy_seen);
        checks++;
        if (rise !== LAT || highs !== 2) begin
            errors++;
            $display("FAIL reset_reburst: got rise %0d pulses %0d want %0d 2", rise, highs, LAT);
        end
    endtask

    initial begin
        test_reset();
        test_functional();
        test_basic_burst();
        test_random_bursts();
        test_abort_settle();
        test_abort_pulse();
        test_mode();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
